// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the load/run sequencer: FSM state encoding and
// bit positions of the status word exposed through the slave register map.
package riscv_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_LOAD  = 3'd2,
        ST_RUN   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Status register bit positions as seen by software
    localparam int STAT_BUSY_BIT      = 0;
    localparam int STAT_DONE_BIT      = 1;
    localparam int STAT_START_IGN_BIT = 2;

endpackage

// File: rtl/riscv_sync_fifo.sv
// Single-clock FIFO for instruction words. Head word is visible on pop_data
// while not empty; flush empties the buffer and overrides push/pop.
module riscv_sync_fifo #(
    parameter int  DATA_W     = 32,
    parameter int  FIFO_DEPTH = 8,
    localparam int PTR_W      = $clog2(FIFO_DEPTH),
    localparam int LVL_W      = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    input  logic              flush,
    output logic              full,
    output logic              empty,
    output logic [LVL_W-1:0]  level
);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full     = (level == LVL_W'(FIFO_DEPTH));
    assign empty    = (level == '0);
    assign do_push  = push && !full && !flush;
    assign do_pop   = pop && !empty && !flush;
    assign pop_data = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-2 depth)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            level <= level + LVL_W'(do_push) - LVL_W'(do_pop);
        end
    end

    // Storage array, no reset needed
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/riscv_load_run_ctrl.sv
// Load/run sequencer: buffers host instruction words, then on start clears
// instruction memory, writes the buffered words, and runs the core.
module riscv_load_run_ctrl
    import riscv_ctrl_pkg::*;
#(
    parameter int  DATA_W     = 32,
    parameter int  ADDR_W     = 32,
    parameter int  FIFO_DEPTH = 8,
    parameter int  CLR_CYCLES = 4,
    parameter int  ADDR_STEP  = 4,
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1,
    localparam int CLR_W      = $clog2(CLR_CYCLES + 1)
) (
    input  logic              s00_axi_aclk,
    input  logic              s00_axi_aresetn,
    input  logic              word_valid,
    input  logic [DATA_W-1:0] word_data,
    output logic              word_ready,
    input  logic              start,
    input  logic              abort,
    input  logic [15:0]       cfg_num_words,
    input  logic [ADDR_W-1:0] cfg_base_addr,
    input  logic [31:0]       cfg_run_cycles,
    output logic              mem_reset_n,
    output logic              run_pc_in,
    output logic              instruction_write,
    output logic [DATA_W-1:0] instruction_data,
    output logic [ADDR_W-1:0] instruction_addr,
    output logic              busy,
    output logic              done,
    output logic              start_ignored,
    output logic [LVL_W-1:0]  fifo_level,
    output logic [2:0]        state_o,
    output logic [31:0]       run_count
);

    state_t            state, state_nx;
    logic [CLR_W-1:0]  clr_cnt;
    logic [15:0]       num_words_q;
    logic [15:0]       pop_cnt;
    logic [ADDR_W-1:0] load_addr;
    logic [31:0]       run_cycles_q;
    logic              fifo_full, fifo_empty, fifo_pop;
    logic [DATA_W-1:0] fifo_head;
    logic              start_ok, start_busy, run_last;

    assign word_ready = !fifo_full;
    assign state_o    = state;

    riscv_sync_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (s00_axi_aclk),
        .rst_n     (s00_axi_aresetn),
        .push      (word_valid),
        .push_data (word_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .flush     (abort),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    // Next-state and per-cycle control; abort overrides everything
    always_comb begin
        state_nx   = state;
        start_ok   = 1'b0;
        start_busy = 1'b0;
        fifo_pop   = 1'b0;
        run_last   = 1'b0;
        if (abort) begin
            state_nx = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        start_ok = 1'b1;
                        state_nx = ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    start_busy = start;
                    if (clr_cnt == CLR_W'(1))
                        state_nx = (num_words_q != 16'd0) ? ST_LOAD : ST_RUN;
                end
                ST_LOAD: begin
                    start_busy = start;
                    // all words popped: this cycle shows the final write
                    if (pop_cnt == num_words_q) state_nx = ST_RUN;
                    else                        fifo_pop = !fifo_empty;
                end
                ST_RUN: begin
                    start_busy = start;
                    if (run_cycles_q != 32'd0 && run_count == run_cycles_q - 32'd1) begin
                        run_last = 1'b1;
                        state_nx = ST_DONE;
                    end
                end
                default: state_nx = ST_IDLE;
            endcase
        end
    end

    // State register
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) state <= ST_IDLE;
        else                  state <= state_nx;
    end

    // Registered outputs, config latches and counters
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            mem_reset_n       <= 1'b0;
            run_pc_in         <= 1'b0;
            busy              <= 1'b0;
            instruction_write <= 1'b0;
            instruction_data  <= '0;
            instruction_addr  <= '0;
            done              <= 1'b0;
            start_ignored     <= 1'b0;
            run_count         <= '0;
            clr_cnt           <= '0;
            num_words_q       <= '0;
            pop_cnt           <= '0;
            load_addr         <= '0;
            run_cycles_q      <= '0;
        end else begin
            mem_reset_n       <= (state_nx != ST_CLEAR);
            run_pc_in         <= (state_nx == ST_RUN);
            busy              <= (state_nx == ST_CLEAR) || (state_nx == ST_LOAD) || (state_nx == ST_RUN);
            instruction_write <= fifo_pop;
            if (fifo_pop) begin
                instruction_data <= fifo_head;
                instruction_addr <= load_addr;
                load_addr        <= load_addr + ADDR_W'(ADDR_STEP);
                pop_cnt          <= pop_cnt + 16'd1;
            end
            if (state == ST_CLEAR) clr_cnt <= clr_cnt - CLR_W'(1);
            if (state == ST_RUN && !abort) run_count <= run_count + 32'd1;
            if (start_busy) start_ignored <= 1'b1;
            if (run_last)   done <= 1'b1;
            if (abort)      done <= 1'b0;
            if (start_ok) begin
                num_words_q   <= cfg_num_words;
                load_addr     <= cfg_base_addr;
                run_cycles_q  <= cfg_run_cycles;
                clr_cnt       <= CLR_W'(CLR_CYCLES);
                pop_cnt       <= '0;
                run_count     <= '0;
                done          <= 1'b0;
                start_ignored <= 1'b0;
            end
        end
    end

endmodule

// File: doc/riscv_load_run_ctrl.md
Name: riscv_load_run_ctrl

Overview:
Sequencer between the AXI4-Lite register slave and the single-cycle RISC-V core. It buffers instruction words pushed from the AXI side in a small FIFO. On a start command it clears instruction memory, writes the buffered words to consecutive addresses, and then runs the core for a programmed number of cycles. It owns the core's mem_reset_n, run_pc_in and instruction_write/data/addr inputs and reports status back to readable slave registers.

Parameters:
DATA_W, 32, instruction word width
ADDR_W, 32, instruction address width
FIFO_DEPTH, 8, instruction word buffer depth (power of 2, >=2)
CLR_CYCLES, 4, cycles mem_reset_n is held low in CLEAR (>=1)
ADDR_STEP, 4, address increment per word (byte addressing)

Ports:
s00_axi_aclk  in  1  clock
s00_axi_aresetn  in  1  asynchronous active-low reset
word_valid  in  1  instruction word offered
word_data  in  DATA_W  instruction word
word_ready  out  1  FIFO can accept; equals !full
start  in  1  single-cycle start pulse
abort  in  1  single-cycle abort pulse
cfg_num_words  in  16  words to load (0 = skip LOAD)
cfg_base_addr  in  ADDR_W  first write address
cfg_run_cycles  in  32  RUN length (0 = run until abort)
mem_reset_n  out  1  core instruction-memory reset
run_pc_in  out  1  core PC enable
instruction_write  out  1  memory write strobe
instruction_data  out  DATA_W  memory write data
instruction_addr  out  ADDR_W  memory write address
busy  out  1  state is CLEAR, LOAD or RUN
done  out  1  sticky, set on RUN completion
start_ignored  out  1  sticky, set when start arrives while busy
fifo_level  out  $clog2(FIFO_DEPTH)+1  words buffered
state_o  out  3  IDLE=0 CLEAR=1 LOAD=2 RUN=3 DONE=4
run_count  out  32  cycles spent in current/last RUN

Behaviour:
- All outputs registered. Reset values: state IDLE, mem_reset_n=0, run_pc_in=0, instruction_write=0, data/addr=0, done=0, start_ignored=0, run_count=0, FIFO empty.
- mem_reset_n=0 in reset and in CLEAR; it rises on the first clock edge after reset release.
- FIFO push when word_valid && word_ready, in any state, so the host may preload before start. word_ready depends only on full. Push and pop in the same cycle are legal when not full.
- start is accepted only in IDLE or DONE. On acceptance: latch cfg_*, clear done, start_ignored and run_count, load the clear counter with CLR_CYCLES, go to CLEAR.
- A start in CLEAR, LOAD or RUN is ignored and sets start_ignored.
- CLEAR: mem_reset_n=0 for exactly CLR_CYCLES cycles. Then go to LOAD if num_words>0, otherwise RUN.
- LOAD: on each cycle the FIFO is non-empty, pop one word. On the next cycle drive instruction_write=1, instruction_data=word, instruction_addr=base+idx*ADDR_STEP, where idx counts 0..num_words-1. An empty FIFO stalls LOAD with instruction_write=0, with no timeout. After the write for idx=num_words-1, go to RUN. Address arithmetic wraps mod 2^ADDR_W.
- RUN: run_pc_in=1 and run_count increments every cycle. If run_cycles!=0 and run_count reaches run_cycles, drop run_pc_in the next cycle and go to DONE with done=1. run_pc_in is high for exactly run_cycles cycles.
- DONE: hold run_count and done. Leave only on start or abort.
- abort in any state: go to IDLE on the next edge. run_pc_in=0, instruction_write=0, mem_reset_n=1. FIFO flushed, done cleared, run_count held.
- abort and start in the same cycle: abort wins and start is dropped. abort and push in the same cycle: the word is discarded.
- Words left in the FIFO after LOAD completes remain for the next start.

Decomposition:
- Package riscv_ctrl_pkg: state encoding constants (IDLE..DONE), status bit positions for the slave register map.
- One sub-module, riscv_sync_fifo: synchronous FIFO with parameters DATA_W and FIFO_DEPTH; ports push, pop, flush, full, empty, level.

Test Plan:
- Preload 3 words (0x00500093, 0x00108113, 0x0000006F), base 0x0, num_words=3, run_cycles=10, start -> mem_reset_n low 4 cycles; writes to addr 0x0, 0x4, 0x8 on consecutive cycles; run_pc_in high exactly 10 cycles; done=1, run_count=10, state_o=4.
- Start with empty FIFO, num_words=2; push 1st word 5 cycles later and 2nd 3 cycles after that -> LOAD stalls with instruction_write=0; each write appears one cycle after its pop; RUN follows the 2nd write.
- Push 9 words with FIFO_DEPTH=8 and no start -> word_ready=0 after the 8th; 9th not accepted; fifo_level=8.
- run_cycles=0, abort asserted after 100 RUN cycles -> run_pc_in drops next cycle, state IDLE, run_count=100, done=0.
- Start pulse during RUN -> start_ignored=1, RUN unaffected; start and abort in the same cycle -> IDLE, no new run.
- Reset asserted mid-LOAD -> all outputs at reset values asynchronously; FIFO empty; mem_reset_n=0 until the first edge after release.
